leap_frame_rx: RTL and testbench



---
 rtl/leap_rx_pkg.sv | 19 +
 rtl/leap_frame_rx_if.sv | 29 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/leap_frame_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_leap_frame_rx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/leap_rx_pkg.sv
// Shared types and helpers for the leap_frame_rx serial frame receiver.
package leap_rx_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    function automatic int unsigned frame_w(input int unsigned n);
        return n * BYTE_W;
    endfunction

endpackage

// File: rtl/leap_frame_rx_if.sv
// Serial line in, packed frame and status pulses out, between the receiver and its consumer.
interface leap_frame_rx_if #(
    parameter int unsigned NUM_BYTES = 20
);
    import leap_rx_pkg::*;

    localparam int unsigned FRAME_W = frame_w(NUM_BYTES);
    localparam int unsigned IDX_W   = $clog2(NUM_BYTES + 1);

    logic               serial;
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;
    logic               framing_err;
    logic               gap_err;
    logic               parity_err;
    logic [IDX_W-1:0]   byte_idx;
    logic               busy;

    modport master (
        input  serial,
        output frame, frame_valid, framing_err, gap_err, parity_err, byte_idx, busy
    );

    modport slave (
        output serial,
        input  frame, frame_valid, framing_err, gap_err, parity_err, byte_idx, busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, resetting to the line idle level (1).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/leap_frame_rx.sv
// 8N1 serial receiver packing NUM_BYTES bytes into one atomically updated frame.
// Optional even-parity bit per byte when LEAP_RX_PARITY_EN is defined.
module leap_frame_rx
    import leap_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1600,
    parameter int unsigned NUM_BYTES    = 20,
    parameter int unsigned GAP_CLKS     = 16 * CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           rst_n,
    leap_frame_rx_if.master bus
);

    localparam int unsigned FRAME_W = frame_w(NUM_BYTES);
    localparam int unsigned IDX_W   = $clog2(NUM_BYTES + 1);
    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned GAP_W   = $clog2(GAP_CLKS + 1);

    state_t             state_q, state_d;
    logic               busy_q;
    logic               s_q;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]  shreg_q, shreg_d;
    logic [FRAME_W-1:0] stage_q, stage_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               commit_q, commit_d;
    logic               frame_valid_q, frame_valid_d;
    logic               framing_err_q, framing_err_d;
    logic               gap_err_q, gap_err_d;
    logic               half_c, sample_c, timeout_c;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.serial),
        .q     (s_q)
    );

    assign half_c    = (bit_cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign sample_c  = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign timeout_c = (state_q == IDLE) && (byte_idx_q != '0) && (gap_cnt_q == GAP_W'(GAP_CLKS));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!s_q) state_d = START;
            START:     if (half_c) state_d = s_q ? IDLE : DATA;
            DATA: begin
                if (sample_c && bit_idx_q == 3'd7) begin
`ifdef LEAP_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef LEAP_RX_PARITY_EN
            PARITY:    if (sample_c) state_d = STOP;
`endif
            STOP:      if (sample_c) state_d = s_q ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (s_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

`ifdef LEAP_RX_PARITY_EN
    logic drop_q, drop_d;
    logic parity_err_q, parity_err_d;
`endif

    // Datapath / output next values
    always_comb begin
        bit_idx_d     = bit_idx_q;
        shreg_d       = shreg_q;
        stage_d       = stage_q;
        frame_d       = frame_q;
        byte_idx_d    = byte_idx_q;
        commit_d      = 1'b0;
        frame_valid_d = 1'b0;
        framing_err_d = 1'b0;
        gap_err_d     = 1'b0;
`ifdef LEAP_RX_PARITY_EN
        drop_d        = drop_q;
        parity_err_d  = 1'b0;
`endif

        if (state_d != state_q || state_q == IDLE || state_q == WAIT_HIGH || sample_c)
            bit_cnt_d = '0;
        else
            bit_cnt_d = bit_cnt_q + CNT_W'(1);

        // Gap timer only runs while a partial frame waits on an idle-high line
        if (timeout_c) begin
            gap_cnt_d  = '0;
            gap_err_d  = 1'b1;
            byte_idx_d = '0;
        end else if (state_q == IDLE && byte_idx_q != '0 && s_q)
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        else
            gap_cnt_d = '0;

        if (commit_q) begin
            frame_d       = stage_q;
            frame_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!s_q) begin
                    bit_idx_d = '0;
`ifdef LEAP_RX_PARITY_EN
                    drop_d    = 1'b0;
`endif
                end
            end
            DATA: begin
                if (sample_c) begin
                    for (int i = 0; i < BYTE_W; i++)
                        if (bit_idx_q == 3'(i)) shreg_d[i] = s_q;
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
`ifdef LEAP_RX_PARITY_EN
            PARITY: begin
                if (sample_c && (s_q != (^shreg_q))) begin
                    parity_err_d = 1'b1;
                    drop_d       = 1'b1;
                    byte_idx_d   = '0;
                end
            end
`endif
            STOP: begin
                if (sample_c) begin
                    if (!s_q) begin
                        framing_err_d = 1'b1;
                        byte_idx_d    = '0;
                    end
`ifdef LEAP_RX_PARITY_EN
                    else if (!drop_q) begin
`else
                    else begin
`endif
                        for (int i = 0; i < NUM_BYTES; i++)
                            if (byte_idx_q == IDX_W'(i)) stage_d[i*BYTE_W +: BYTE_W] = shreg_q;
                        if (byte_idx_q == IDX_W'(NUM_BYTES - 1)) begin
                            commit_d   = 1'b1;
                            byte_idx_d = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            stage_q       <= '0;
            frame_q       <= '0;
            byte_idx_q    <= '0;
            gap_cnt_q     <= '0;
            commit_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            framing_err_q <= 1'b0;
            gap_err_q     <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            stage_q       <= stage_d;
            frame_q       <= frame_d;
            byte_idx_q    <= byte_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            commit_q      <= commit_d;
            frame_valid_q <= frame_valid_d;
            framing_err_q <= framing_err_d;
            gap_err_q     <= gap_err_d;
        end
    end

`ifdef LEAP_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            drop_q       <= drop_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.frame       = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.framing_err = framing_err_q;
    assign bus.gap_err     = gap_err_q;
    assign bus.byte_idx    = byte_idx_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_leap_frame_rx.sv
// Scoreboard bench for leap_frame_rx: expected frames are queued as bytes are sent, a monitor checks each frame_valid.
module tb_leap_frame_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned NB  = 3;
    localparam int unsigned GAP = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    leap_frame_rx_if #(.NUM_BYTES(NB)) bus ();

    leap_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .NUM_BYTES    (NB),
        .GAP_CLKS     (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ferr  = 0;
    int n_gerr  = 0;
    int n_perr  = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pulse counting and frame scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.framing_err) n_ferr++;
            if (bus.gap_err)     n_gerr++;
            if (bus.parity_err)  n_perr++;
            if (bus.frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("frame_expected_queued", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    check("frame", 32'(bus.frame), 32'(e));
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.serial = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic line_bit(input logic b);
        bus.serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef LEAP_RX_PARITY_EN
        line_bit(^d);
`endif
        line_bit(stop);
    endtask

`ifdef LEAP_RX_PARITY_EN
    task automatic send_byte_par(input logic [7:0] d, input logic par);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(d[i]);
        line_bit(par);
        line_bit(1'b1);
    endtask
`endif

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, f0;
        bus.serial = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_frame", 32'(bus.frame), 32'd0);
        check("rst_byte_idx", 32'(bus.byte_idx), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.frame_valid), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Back-to-back frame
        exp_q.push_back(24'h013CA5);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h01, 1'b1);
        drain("frame1_drain");
        check("frame1_byte_idx", 32'(bus.byte_idx), 32'd0);
        idle(20);

        // Short low glitch
        g0 = n_gerr; f0 = n_ferr;
        bus.serial = 1'b0;
        repeat (4) @(negedge clk);
        bus.serial = 1'b1;
        check("glitch_busy_start", 32'(bus.busy), 32'd1);
        idle(20);
        check("glitch_busy_idle", 32'(bus.busy), 32'd0);
        check("glitch_byte_idx", 32'(bus.byte_idx), 32'd0);
        check("glitch_ferr", 32'(n_ferr), 32'(f0));
        check("glitch_gerr", 32'(n_gerr), 32'(g0));

        // Bad stop bit then held-low break
        f0 = n_ferr;
        send_byte(8'h11, 1'b1);
        check("ferr_byte_idx_pre", 32'(bus.byte_idx), 32'd1);
        send_byte(8'h22, 1'b0);
        bus.serial = 1'b0;
        repeat (100) @(negedge clk);
        check("ferr_count", 32'(n_ferr), 32'(f0 + 1));
        check("ferr_byte_idx", 32'(bus.byte_idx), 32'd0);
        check("ferr_break_busy", 32'(bus.busy), 32'd1);
        idle(10);
        check("ferr_release_busy", 32'(bus.busy), 32'd0);
        exp_q.push_back(24'h665544);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        drain("frame2_drain");

        // Inter-byte gap timeout
        g0 = n_gerr;
        send_byte(8'h77, 1'b1);
        check("gap_byte_idx_pre", 32'(bus.byte_idx), 32'd1);
        idle(240);
        check("gap_not_early", 32'(n_gerr), 32'(g0));
        idle(60);
        check("gap_count", 32'(n_gerr), 32'(g0 + 1));
        check("gap_byte_idx", 32'(bus.byte_idx), 32'd0);
        check("gap_frame_held", 32'(bus.frame), 32'h665544);

        // Reset in the middle of a byte
        send_byte(8'h09, 1'b1);
        line_bit(1'b0);
        line_bit(1'b1);
        line_bit(1'b0);
        line_bit(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_frame", 32'(bus.frame), 32'd0);
        check("mrst_byte_idx", 32'(bus.byte_idx), 32'd0);
        check("mrst_pulses", {29'd0, bus.frame_valid, bus.framing_err, bus.gap_err}, 32'd0);
        rst_n = 1'b1;
        idle(10);
        exp_q.push_back(24'h030201);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        drain("frame3_drain");

`ifdef LEAP_RX_PARITY_EN
        idle(10);
        send_byte_par(8'h07, 1'b0);
        check("par_err_count", 32'(n_perr), 32'd1);
        check("par_byte_idx", 32'(bus.byte_idx), 32'd0);
        send_byte_par(8'h07, 1'b1);
        check("par_ok_byte_idx", 32'(bus.byte_idx), 32'd1);
        exp_q.push_back(24'h090807);
        send_byte(8'h08, 1'b1);
        send_byte(8'h09, 1'b1);
        drain("frame_par_drain");
`else
        check("parity_tied_low", 32'(n_perr), 32'd0);
`endif

        idle(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
